dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
//  Word-organised 16-bit data memory that answers the CPU's LW/SW requests over a req/ack handshake.
//  The CPU is the initiator and this block is the responder on the data side.
//  Fixed, parameterised wait-state latency; reports misaligned or out-of-range accesses via err.
//  Sits beside the register file/ALU datapath; rdata feeds the MemtoReg mux.
// PARAMETERS
//  ADDR_W       10   word-address width; MEM_DEPTH = 2**ADDR_W words
//  DATA_W       16   data word width (equals CPU datapath width)
//  WAIT_CYCLES  1    extra cycles between accept and ack (0..15)
// PORTS
//  clock   in   1       single clock; all state changes on posedge clock
//  reset   in   1       synchronous, active-high
//  req     in   1       CPU access request
//  we      in   1       1 = store (SW), 0 = load (LW); sampled with req
//  addr    in   16      byte address; word index = addr[ADDR_W:1]
//  wdata   in   DATA_W  store data; sampled with req
//  busy    out  1       high from accept through the ack cycle inclusive
//  ack     out  1       one-cycle pulse: access complete
//  err     out  1       valid only with ack; 1 = misaligned or out of range
//  rdata   out  DATA_W  load data; valid with ack, held until next accept
// BEHAVIOUR
//  - Reset (sync, active-high): state=IDLE; busy=0, ack=0, err=0, rdata=0.
//    Memory contents are NOT cleared. Reset wins over any other event in the same cycle.
//  - FSM states: IDLE, WAIT, RESP.
//    IDLE: if req=1, accept the request. Latch we/addr/wdata; busy=1 from the next cycle.
//          Go to WAIT if WAIT_CYCLES>0, else to RESP.
//    WAIT: down-counter loaded with WAIT_CYCLES-1 on accept; at 0 go to RESP.
//    RESP: ack=1 for exactly one cycle, then go to IDLE.
//  - Latency: ack is asserted WAIT_CYCLES+1 cycles after the accepting edge.
//  - Handshake:
//    - req is only sampled in IDLE. Inputs may change or drop after accept; latched copies are used.
//    - req held high across ack is a new request, accepted in the first IDLE cycle after RESP.
//    - Back-to-back throughput is one access per WAIT_CYCLES+2 cycles.
//  - Error check on latched addr:
//    - err=1 if addr[0]=1 (misaligned), or if addr[15:ADDR_W+1] is nonzero (out of range).
//    - On err: no write; rdata=0.
//  - Store: array write commits on the RESP edge (same cycle ack rises); rdata is unchanged.
//  - Load: rdata <= mem[word index] registered on the RESP edge.
//    A load immediately after a store to the same word returns the new data.
//  - Reset mid-access (WAIT or RESP): the access is abandoned with no ack, and a pending store is discarded.
//  - ack/err are never asserted outside RESP; err=0 whenever ack=0.
// STRUCTURE
//  - dmem_defs.vh: state encodings (IDLE=2'b00, WAIT=2'b01, RESP=2'b10) and the DATA_W default.
//    It is shared with the future CPU-side memory initiator.
//  - Sub-module dmem_array(clock, we, waddr, wdata, raddr, rdata):
//    - 2**ADDR_W x DATA_W array, sync write, async read.
//    - Includes an initial-load hook for test data.
//  - Top level holds the FSM, the wait counter, the latched request and the error decode.
// TESTING
//  1. reset=1 for 2 cycles with req=1 -> busy=ack=err=0, rdata=0; after release, the request is accepted.
//  2. SW addr=16'h0004 wdata=16'h00AF, then LW addr=16'h0004
//     -> ack at accept+2 (WAIT_CYCLES=1), err=0, rdata=16'h00AF.
//  3. LW addr=16'h0003 -> ack=1, err=1, rdata=0.
//     SW addr=16'h0800 wdata=16'h1234 -> err=1; a later LW 16'h0000 is unchanged.
//  4. req held high for 8 cycles (alternating SW/LW to 16'h0010) -> acks every 3 cycles, never two consecutive.
//  5. Accept SW addr=16'h0006 wdata=16'hBEEF, assert reset in WAIT
//     -> no ack; a later LW 16'h0006 returns the prior value.
//  6. WAIT_CYCLES=0 build: LW accepted at cycle n -> ack at n+1; busy high for exactly 1 cycle.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared state encodings, defaults and address decode for the data memory
package dmem_responder_pkg;

    localparam int DMEM_DATA_W = 16;
    localparam int DMEM_ADDR_BITS = 16;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } dmem_state_e;

    // Byte address is faulty if odd or if any bit above the word index is set.
    function automatic logic addr_fault(input logic [DMEM_ADDR_BITS-1:0] addr, input int addr_w);
        return addr[0] || ((addr >> (addr_w + 1)) != '0);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - CPU data-side req/ack bus between initiator and data memory
interface dmem_responder_if #(
    parameter int DATA_W = 16
);
    logic              req;
    logic              we;
    logic [15:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic              busy;
    logic              ack;
    logic              err;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  busy, ack, err, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output busy, ack, err, rdata
    );
endinterface

// File: rtl/dmem_responder_array.sv
// rtl/dmem_responder_array.sv - word array with synchronous write and asynchronous read
// mem is deliberately left unreset so test data can be preloaded by hierarchical reference.
module dmem_responder_array #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data memory responder: FSM, wait counter, latched request and error decode
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = DMEM_DATA_W,
    parameter int WAIT_CYCLES = 1
) (
    input  logic             clock,
    input  logic             reset,
    dmem_responder_if.slave  bus
);

    dmem_state_e state, state_next;

    logic [3:0]        cnt_q;
    logic              we_q;
    logic [15:0]       addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;

    logic              accept;
    logic              enter_resp;
    logic              cur_we;
    logic [15:0]       cur_addr;
    logic [DATA_W-1:0] cur_wdata;
    logic              cur_err;
    logic [ADDR_W-1:0] word_idx;
    logic              arr_we;
    logic [DATA_W-1:0] arr_rdata;

    assign accept = (state == IDLE) && bus.req;

    // With no wait states RESP follows the accept directly, so the live bus feeds the array.
    assign cur_we    = (state == IDLE) ? bus.we    : we_q;
    assign cur_addr  = (state == IDLE) ? bus.addr  : addr_q;
    assign cur_wdata = (state == IDLE) ? bus.wdata : wdata_q;
    assign cur_err   = addr_fault(cur_addr, ADDR_W);
    assign word_idx  = cur_addr[ADDR_W:1];

    assign enter_resp = (state_next == RESP);
    assign arr_we     = enter_resp && cur_we && !cur_err && !reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.req) state_next = (WAIT_CYCLES > 0) ? WAIT : RESP;
            WAIT: if (cnt_q == 4'd0) state_next = RESP;
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.busy  = (state != IDLE);
        bus.ack   = (state == RESP);
        bus.err   = (state == RESP) && err_q;
        bus.rdata = rdata_q;
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            we_q    <= bus.we;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                cnt_q <= 4'(WAIT_CYCLES - 1);
            end else if (state == WAIT && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            // rdata is registered as RESP is entered so it is valid alongside ack.
            if (enter_resp) begin
                err_q <= cur_err;
                if (cur_err) begin
                    rdata_q <= '0;
                end else if (!cur_we) begin
                    rdata_q <= arr_rdata;
                end
            end
        end
    end

    dmem_responder_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clock (clock),
        .we    (arr_we),
        .waddr (word_idx),
        .wdata (cur_wdata),
        .raddr (word_idx),
        .rdata (arr_rdata)
    );

endmodule
